uvmt_cv32e40x_rvfi_evt_tracker: RTL
===================================

Name: uvmt_cv32e40x_rvfi_evt_tracker

Overview:
Parametrised RVFI event tracker for the cv32e40x uvmt bench. It takes NUM_EVT per-retirement event flags, which the bench derives from the rvfi_if support logic (split datatrans, pushpop, tablejump, ...). For each event it keeps a trap-qualified saturating hit counter and a sticky hit mask. It also runs one A-then-B sequence detector with a retirement window and tracks the maximum retirement gap for one selected event. It is bound beside the RVFI cover module, and its outputs feed both formal cover/assert properties and the sim coverage report.

Parameters:
NUM_EVT, 4, number of event channels (1..32)
CNT_W, 16, width of each per-event counter
TRAP_CARE, 4'b1111, per-event: 1 = qualify the event with trap_i, 0 = ignore trap_i
TRAP_POL, 4'b1000, per-event: required trap_i value when TRAP_CARE=1
SEQ_A, 0, event index that arms the sequence detector
SEQ_B, 2, event index that completes the sequence
WINDOW, 8, number of retirements after A during which B counts (1..255)
GAP_EVT, 1, event index whose inter-occurrence gap is tracked
GAP_W, 12, width of the gap counter and max_gap_o

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
valid_i  in  1  rvfi_valid; one retirement this cycle
trap_i  in  1  rvfi_trap of this retirement (any bit set)
evt_i  in  NUM_EVT  raw event flags; ignored when valid_i=0
clr_i  in  1  synchronous clear of all state
evt_cnt_o  out  NUM_EVT*CNT_W  packed counters; channel k at [k*CNT_W +: CNT_W]
hit_mask_o  out  NUM_EVT  sticky: channel k has fired at least once
all_hit_o  out  1  &hit_mask_o, registered
seq_hit_o  out  1  one-cycle pulse when sequence A..B completes
seq_cnt_o  out  CNT_W  saturating count of completed sequences
max_gap_o  out  GAP_W  largest retirement gap seen between GAP_EVT occurrences

Behaviour:
- Reset (rst_ni=0, async): all outputs and internal state are 0; FSM is IDLE; gap counter is 0 and gap_armed=0.
- Qualified event: q[k] = valid_i & evt_i[k] & (!TRAP_CARE[k] | (trap_i == TRAP_POL[k])).
- Counters: on q[k], evt_cnt[k] increments by 1 and holds at 2^CNT_W-1 with no wrap. Outputs update the cycle after the qualifying retirement (latency 1).
- hit_mask[k] is set on q[k] and is never cleared except by reset or clr_i. all_hit_o follows hit_mask with 1 cycle of additional latency.
- Sequence FSM states: IDLE, ARMED, HIT.
  - IDLE: q[SEQ_A] moves to ARMED with win_cnt=WINDOW. If A and B occur on the same retirement, only A is taken; B does not complete.
  - ARMED, on each valid_i: if q[SEQ_B], go to HIT and increment seq_cnt (saturating). Else if q[SEQ_A], reload win_cnt=WINDOW. Else decrement win_cnt; at 1 -> 0, go to IDLE. B takes priority over A re-arm. Cycles with valid_i=0 do not consume the window.
  - HIT: seq_hit_o=1 for exactly this cycle, then IDLE. If q[SEQ_A] occurs in HIT, go directly to ARMED.
- Gap tracker: the first q[GAP_EVT] sets gap_armed and zeroes gap_cnt. While armed, each valid_i without q[GAP_EVT] increments gap_cnt, saturating. On each later q[GAP_EVT]: max_gap = max(max_gap, gap_cnt), then gap_cnt=0. A gap is therefore the number of retirements strictly between two occurrences.
- clr_i: next cycle, all state is back at reset values. clr_i wins over any event on the same cycle, and that event is dropped.
- Reset mid-sequence: FSM returns to IDLE immediately and seq_hit_o deasserts asynchronously.
- Elaboration checks: SEQ_A, SEQ_B and GAP_EVT must be < NUM_EVT, and SEQ_A != SEQ_B. A violation raises $error.

Decomposition:
- Package uvmt_cv32e40x_rvfi_evt_pkg holds:
  - the seq_state_e enum (IDLE, ARMED, HIT);
  - default parameter constants;
  - the function sat_inc(value, width).
- Sub-module uvmt_cv32e40x_rvfi_sat_cnt: a CNT_W saturating counter with inc and clr inputs and the same async reset. It is instantiated NUM_EVT+1 times (per-event counters plus seq_cnt).

Test Plan:
1. Reset, then 3 retirements with evt_i=4'b0001, trap_i=0 -> evt_cnt[0]=3, hit_mask_o=4'b0001, all_hit_o=0.
2. evt_i[3] with trap_i=0, then with trap_i=1 (TRAP_POL[3]=1) -> evt_cnt[3]=1. evt_i[0] with trap_i=1 -> evt_cnt[0] unchanged.
3. A, then 7 empty retirements (with valid_i=0 gaps interleaved), then B -> seq_hit_o pulses 1 cycle, seq_cnt_o=1. Repeat with 8 empty retirements -> no hit, FSM IDLE.
4. A and B on the same retirement, then B on the next retirement -> seq_cnt_o=1. The first B is ignored.
5. GAP_EVT occurrences separated by 5, then 2, then 9 retirements -> max_gap_o=5, 5, 9. Force the counter to 2^CNT_W-2 and drive 3 more events -> value saturates at 2^CNT_W-1.
6. Assert clr_i in the same cycle as evt_i=4'b1111 while ARMED, then rst_ni low mid-window -> counters, mask and FSM are zero/IDLE. No seq_hit_o.

Source files
------------

// File: rtl/uvmt_cv32e40x_rvfi_evt_pkg.sv
// Shared types, defaults and helpers for the RVFI event tracker.
package uvmt_cv32e40x_rvfi_evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_EVT = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_SEQ_A   = 0;
  localparam int DEF_SEQ_B   = 2;
  localparam int DEF_WINDOW  = 8;
  localparam int DEF_GAP_EVT = 1;
  localparam int DEF_GAP_W   = 12;

  // Increment that sticks at the all-ones value of a width-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= top) ? top : value + 32'd1;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_rvfi_sat_cnt.sv
// Saturating counter with synchronous clear; one per event channel plus one for sequences.
module uvmt_cv32e40x_rvfi_sat_cnt
  import uvmt_cv32e40x_rvfi_evt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count qualified hits, hold at max, clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
  end

endmodule

// File: rtl/uvmt_cv32e40x_rvfi_evt_tracker.sv
// RVFI event tracker: per-event hit counters and sticky mask, an A-then-B
// sequence detector with a retirement window, and a max-gap tracker.
module uvmt_cv32e40x_rvfi_evt_tracker
  import uvmt_cv32e40x_rvfi_evt_pkg::*;
#(
  parameter int                 NUM_EVT   = DEF_NUM_EVT,
  parameter int                 CNT_W     = DEF_CNT_W,
  parameter logic [NUM_EVT-1:0] TRAP_CARE = NUM_EVT'(4'b1111),
  parameter logic [NUM_EVT-1:0] TRAP_POL  = NUM_EVT'(4'b1000),
  parameter int                 SEQ_A     = DEF_SEQ_A,
  parameter int                 SEQ_B     = DEF_SEQ_B,
  parameter int                 WINDOW    = DEF_WINDOW,
  parameter int                 GAP_EVT   = DEF_GAP_EVT,
  parameter int                 GAP_W     = DEF_GAP_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic                     trap_i,
  input  logic [NUM_EVT-1:0]       evt_i,
  input  logic                     clr_i,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt_o,
  output logic [NUM_EVT-1:0]       hit_mask_o,
  output logic                     all_hit_o,
  output logic                     seq_hit_o,
  output logic [CNT_W-1:0]         seq_cnt_o,
  output logic [GAP_W-1:0]         max_gap_o
);

  if (SEQ_A >= NUM_EVT || SEQ_B >= NUM_EVT || GAP_EVT >= NUM_EVT || SEQ_A == SEQ_B) begin : g_param_err
    $error("evt_tracker: SEQ_A/SEQ_B/GAP_EVT must be < NUM_EVT and SEQ_A != SEQ_B");
  end

  logic [NUM_EVT-1:0] q;
  seq_state_e         state;
  logic [7:0]         win_cnt;
  logic               seq_inc;
  logic               gap_armed;
  logic [GAP_W-1:0]   gap_cnt;

  // Per-channel trap qualification and hit counter.
  for (genvar k = 0; k < NUM_EVT; k++) begin : g_chan
    assign q[k] = valid_i & evt_i[k] & (~TRAP_CARE[k] | (trap_i == TRAP_POL[k]));

    uvmt_cv32e40x_rvfi_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc    (q[k]),
      .clr    (clr_i),
      .cnt    (evt_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  // Sticky hit mask; all_hit trails the mask by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_mask_o <= '0;
      all_hit_o  <= 1'b0;
    end else if (clr_i) begin
      hit_mask_o <= '0;
      all_hit_o  <= 1'b0;
    end else begin
      hit_mask_o <= hit_mask_o | q;
      all_hit_o  <= &hit_mask_o;
    end
  end

  // Sequence completions are counted on the ARMED -> HIT transition.
  assign seq_inc = (state == ARMED) & q[SEQ_B];

  uvmt_cv32e40x_rvfi_sat_cnt #(.CNT_W(CNT_W)) u_seq_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (seq_inc),
    .clr    (clr_i),
    .cnt    (seq_cnt_o)
  );

  // A-then-B detector; the window only shrinks on retirements, B beats A re-arm.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      win_cnt   <= '0;
      seq_hit_o <= 1'b0;
    end else if (clr_i) begin
      state     <= IDLE;
      win_cnt   <= '0;
      seq_hit_o <= 1'b0;
    end else begin
      seq_hit_o <= 1'b0;
      case (state)
        IDLE: begin
          if (q[SEQ_A]) begin
            state   <= ARMED;
            win_cnt <= 8'(WINDOW);
          end
        end
        ARMED: begin
          if (valid_i) begin
            if (q[SEQ_B]) begin
              state     <= HIT;
              seq_hit_o <= 1'b1;
              win_cnt   <= '0;
            end else if (q[SEQ_A]) begin
              win_cnt <= 8'(WINDOW);
            end else if (win_cnt <= 8'd1) begin
              state   <= IDLE;
              win_cnt <= '0;
            end else begin
              win_cnt <= win_cnt - 8'd1;
            end
          end
        end
        HIT: begin
          if (q[SEQ_A]) begin
            state   <= ARMED;
            win_cnt <= 8'(WINDOW);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Retirements strictly between GAP_EVT occurrences; keep the largest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_armed <= 1'b0;
      gap_cnt   <= '0;
      max_gap_o <= '0;
    end else if (clr_i) begin
      gap_armed <= 1'b0;
      gap_cnt   <= '0;
      max_gap_o <= '0;
    end else if (q[GAP_EVT]) begin
      if (gap_armed && (gap_cnt > max_gap_o)) max_gap_o <= gap_cnt;
      gap_armed <= 1'b1;
      gap_cnt   <= '0;
    end else if (gap_armed && valid_i) begin
      gap_cnt <= GAP_W'(sat_inc(32'(gap_cnt), GAP_W));
    end
  end

endmodule
